// File: rtl/ram_sp.sv
// Single-port-style program/data RAM: one write port and one read port.
// Optional post-reset clear sequencer, registered read with write-first bypass, and a dropped-write flag.
module ram_sp #(
  parameter int              DATA_W         = 8,
  parameter int              ADDR_W         = 8,
  parameter int              READ_LATENCY   = 0,
  parameter int              CLEAR_ON_RESET = 0,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              busy,
  output logic              w_drop
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_drop;
  logic              w_clr_we;
  logic              w_usr_we;
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_clr_we    = 1'b0;
    w_usr_we    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we  = ~reset;
        w_ptr_nxt = r_ptr + ADDR_W'(1);
        // Last address written on this edge hands the array back to the core
        if (&r_ptr) w_state_nxt = S_READY;
      end
      S_READY: begin
        w_usr_we = write_req & ~reset;
      end
      default: w_state_nxt = S_READY;
    endcase
  end

  assign busy = (r_state == S_CLEAR);

  // Memory contents are never reset; only the sequencer or a user write touches them
  always_ff @(posedge clk) begin
    if (w_clr_we)      r_mem[r_ptr]  <= CLEAR_VALUE;
    else if (w_usr_we) r_mem[w_addr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) r_drop <= 1'b0;
    else       r_drop <= write_req & busy;
  end

  assign w_drop = r_drop;

  generate
    if (READ_LATENCY == 0) begin : g_comb_rd
      assign r_data = r_mem[r_addr];
    end else begin : g_reg_rd
      logic [DATA_W-1:0] r_rd;
      always_ff @(posedge clk) begin
        if (reset)                               r_rd <= '0;
        else if (busy)                           r_rd <= CLEAR_VALUE;
        else if (w_usr_we && (w_addr == r_addr)) r_rd <= w_data;
        else                                     r_rd <= r_mem[r_addr];
      end
      assign r_data = r_rd;
    end
  endgenerate

endmodule
